// File: rtl/spi_master_pkg.sv
// Shared types, TMC5130 default settings and sizing helpers for the SPI master.
package spi_master_pkg;

    typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StGap} spi_state_t;

    localparam int unsigned TmcN      = 40;
    localparam int unsigned TmcClkDiv = 13;
    localparam bit          TmcCpol   = 1'b1;
    localparam bit          TmcCpha   = 1'b1;

    // Bit width needed to index 'value' items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK timing: half-period divider plus a count of SCK edges within one frame.
module spi_sck_gen
    import spi_master_pkg::*;
#(
    parameter int unsigned N       = TmcN,
    parameter int unsigned CLK_DIV = TmcClkDiv
) (
    input  logic pclk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o,
    output logic lead_o,
    output logic trail_o,
    output logic last_edge_o
);

    localparam int unsigned CntW  = clog2_min1(CLK_DIV);
    localparam int unsigned EdgeW = $clog2(2 * N + 1);

    logic [CntW-1:0]  cnt_q;
    logic [EdgeW-1:0] edge_q;

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= CntW'(CLK_DIV - 1);
            edge_q <= '0;
        end else if (!en_i) begin
            cnt_q  <= CntW'(CLK_DIV - 1);
            edge_q <= '0;
        end else if (cnt_q == '0) begin
            cnt_q  <= CntW'(CLK_DIV - 1);
            edge_q <= edge_q + 1'b1;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Edges already issued: an even count means the coming edge is a leading one.
    assign tick_o      = en_i && (cnt_q == '0);
    assign lead_o      = tick_o && !edge_q[0];
    assign trail_o     = tick_o && edge_q[0];
    assign last_edge_o = tick_o && (edge_q == EdgeW'(2 * N - 1));

endmodule

// File: rtl/spi_multi_master.sv
// Parametrised full-duplex SPI master: one MSB-first frame per accepted write,
// with programmable mode, divider, chip-select target and CS setup/hold/gap timing.
module spi_multi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned N        = TmcN,
    parameter int unsigned N_CS     = 4,
    parameter int unsigned CLK_DIV  = TmcClkDiv,
    parameter bit          CPOL     = TmcCpol,
    parameter bit          CPHA     = TmcCpha,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic                          pclk_i,
    input  logic                          rst_i,
    input  logic                          wren_i,
    input  logic [N-1:0]                  di_i,
    input  logic [clog2_min1(N_CS)-1:0]   cs_sel_i,
    output logic                          wr_ack_o,
    output logic                          err_o,
    output logic [N-1:0]                  do_o,
    output logic                          do_valid_o,
    output logic                          idle_o,
    output logic                          spi_sck_o,
    output logic                          spi_mosi_o,
    input  logic                          spi_miso_i,
    output logic [N_CS-1:0]               spi_ssel_o
);

    localparam int unsigned TmrMax = (CS_SETUP > CS_HOLD) ?
                                     ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                                     ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int unsigned TmrW = clog2_min1(TmrMax);
    localparam logic [N_CS-1:0] SselLsb = N_CS'(1);

    spi_state_t      state_q;
    logic [TmrW-1:0] tmr_q;
    logic [N-1:0]    tx_q;
    logic [N-1:0]    rx_q;
    logic [N-1:0]    do_q;
    logic [N_CS-1:0] ssel_q;
    logic            sck_q;
    logic            mosi_q;
    logic            ack_q;
    logic            err_q;
    logic            dv_q;
    logic            idle_q;

    logic         tick;
    logic         lead;
    logic         trail;
    logic         last_edge;
    logic         sample;
    logic         shift;
    logic         sel_valid;
    logic [N-1:0] rx_shift;

    spi_sck_gen #(
        .N       (N),
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .pclk_i      (pclk_i),
        .rst_i       (rst_i),
        .en_i        (state_q == StXfer),
        .tick_o      (tick),
        .lead_o      (lead),
        .trail_o     (trail),
        .last_edge_o (last_edge)
    );

    assign sel_valid = 32'(cs_sel_i) < N_CS;
    assign rx_shift  = {rx_q[N-2:0], spi_miso_i};
    assign sample    = CPHA ? trail : lead;
    // In mode CPHA=0 the MSB is already on MOSI from SETUP, so the final trailing edge is idle.
    assign shift     = CPHA ? lead : (trail && !last_edge);

    // ssel_q doubles as the select register: it is written only when a request is accepted.
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            do_q    <= '0;
            ssel_q  <= '1;
            sck_q   <= CPOL;
            mosi_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dv_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (wren_i && sel_valid) begin
                        state_q <= StSetup;
                        tmr_q   <= TmrW'(CS_SETUP - 1);
                        ssel_q  <= ~(SselLsb << cs_sel_i);
                        rx_q    <= '0;
                        ack_q   <= 1'b1;
                        idle_q  <= 1'b0;
                        if (CPHA) begin
                            tx_q <= di_i;
                        end else begin
                            tx_q   <= di_i << 1;
                            mosi_q <= di_i[N-1];
                        end
                    end else if (wren_i) begin
                        err_q <= 1'b1;
                    end
                end
                StSetup: begin
                    if (tmr_q == '0) begin
                        state_q <= StXfer;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                StXfer: begin
                    if (tick) begin
                        sck_q <= ~sck_q;
                    end
                    if (sample) begin
                        rx_q <= rx_shift;
                    end
                    if (shift) begin
                        mosi_q <= tx_q[N-1];
                        tx_q   <= tx_q << 1;
                    end
                    if (last_edge) begin
                        state_q <= StHold;
                        tmr_q   <= TmrW'(CS_HOLD - 1);
                        sck_q   <= CPOL;
                        do_q    <= sample ? rx_shift : rx_q;
                        dv_q    <= 1'b1;
                    end
                end
                StHold: begin
                    if (tmr_q == '0) begin
                        state_q <= StGap;
                        tmr_q   <= TmrW'(CS_GAP - 1);
                        ssel_q  <= '1;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                StGap: begin
                    if (tmr_q == '0) begin
                        state_q <= StIdle;
                        idle_q  <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_ack_o   = ack_q;
    assign err_o      = err_q;
    assign do_o       = do_q;
    assign do_valid_o = dv_q;
    assign idle_o     = idle_q;
    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = mosi_q;
    assign spi_ssel_o = ssel_q;

endmodule

// File: doc/spi_multi_master.md
Name: spi_multi_master

Overview:
Parametrised SPI master, successor to the fixed 40-bit single-slave TMC master. It adds configurable frame width, clock divider, SPI mode (CPOL/CPHA) and N_CS chip selects, plus programmable CS setup, hold and gap timing. It sits between the AXI register bank and a chain of TMC5130 drivers. One frame is carried per write handshake, full-duplex, MSB first.

Parameters:
N, 40, frame width in bits (>=2)
N_CS, 4, number of chip-select lines (>=1)
CLK_DIV, 13, SCK half-period in pclk_i cycles (>=1)
CPOL, 1, SCK idle level
CPHA, 1, 0: sample on leading edge; 1: sample on trailing edge
CS_SETUP, 2, pclk_i cycles from CS assert to the first SCK edge (>=1)
CS_HOLD, 2, pclk_i cycles from the last SCK edge to CS deassert (>=1)
CS_GAP, 4, minimum pclk_i cycles CS stays high between frames (>=1)

Ports:
pclk_i  in  1  system clock; all logic runs on its rising edge
rst_i  in  1  reset, asynchronous, active-high
wren_i  in  1  write request
di_i  in  N  TX frame
cs_sel_i  in  max(1,$clog2(N_CS))  target slave index
wr_ack_o  out  1  one-cycle pulse: request accepted
err_o  out  1  one-cycle pulse: request rejected (cs_sel_i >= N_CS)
do_o  out  N  RX frame, held until the next frame completes
do_valid_o  out  1  one-cycle pulse: do_o updated
idle_o  out  1  high only in IDLE
spi_sck_o  out  1  SPI clock
spi_mosi_o  out  1  SPI data out
spi_miso_i  in  1  SPI data in (synchroniser is external)
spi_ssel_o  out  N_CS  chip selects, active-low

Behaviour:
- Clock and reset: one clock, pclk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, spi_sck_o=CPOL, spi_ssel_o=all ones, spi_mosi_o=0, do_o=0, wr_ack_o=err_o=do_valid_o=0, idle_o=1. Reset asserted mid-frame forces these values immediately. No partial do_valid_o is produced.
- States: IDLE, SETUP, XFER, HOLD, GAP.
- IDLE:
  - wren_i=1 and cs_sel_i<N_CS: latch di_i into the shift register and cs_sel_i into a select register, pulse wr_ack_o, go to SETUP. spi_ssel_o[sel] goes low on the next edge.
  - wren_i=1 and cs_sel_i>=N_CS: pulse err_o, no ack, stay in IDLE.
- wren_i while idle_o=0 is ignored: no ack, no error.
- SETUP: lasts CS_SETUP cycles, then go to XFER.
  - CPHA=0: spi_mosi_o = MSB from SETUP entry.
  - CPHA=1: spi_mosi_o is first driven at the first (leading) edge.
- XFER:
  - A half-period counter reloads to CLK_DIV-1 and emits a tick at 0. Each tick toggles spi_sck_o.
  - 2N ticks per frame, alternating leading and trailing edges.
  - Sample edge: miso shifts into the RX LSB. Shift edge: TX shifts left and MOSI takes the next bit.
  - CPHA=0: sample on leading edges, shift on trailing edges except the last.
  - CPHA=1: shift on leading edges, sample on trailing edges.
  - The bit counter is sized $clog2(2N+1). After tick 2N, spi_sck_o=CPOL; go to HOLD.
- Entering HOLD: do_o<=RX register and do_valid_o pulses on the same edge.
- HOLD lasts CS_HOLD cycles, then spi_ssel_o returns to all ones and the state goes to GAP.
- GAP lasts CS_GAP cycles, then IDLE. The earliest next ack is the first IDLE cycle.
- Frame length in pclk_i cycles: 1 (accept) + CS_SETUP + 2·N·CLK_DIV + CS_HOLD + CS_GAP.
- Exactly one spi_ssel_o bit is low outside IDLE/GAP. The select register cannot change mid-frame.

Decomposition:
- Package spi_master_pkg holds:
  - the state enum typedef spi_state_t (IDLE, SETUP, XFER, HOLD, GAP);
  - the TMC default constants (N=40, CLK_DIV=13, mode 3);
  - function clog2_min1.
- Sub-module spi_sck_gen: half-period counter plus edge counter. Outputs tick, lead/trail and last_edge. The FSM, shift registers and CS decode stay in spi_multi_master.

Test Plan:
- Reset mid-XFER (N=40, CLK_DIV=13, CPOL=1, CPHA=1): assert rst_i at bit 17 -> outputs go to reset values within the same cycle, ssel=4'b1111, sck=1, no do_valid_o.
- Loopback (mosi tied to miso), N=40, mode 3, cs_sel_i=2, di_i=40'hA5_0123_4567:
  - wr_ack_o one pulse, spi_ssel_o=4'b1011.
  - do_o=40'hA5_0123_4567 with do_valid_o after 1+2+1040 cycles.
  - Frame ends with ssel high 2 cycles later.
- Mode 0 (N=8, CLK_DIV=2, CPOL=0, CPHA=0), slave model returns 8'h3C -> MOSI valid before the first rising edge, do_o=8'h3C, 16 SCK toggles, sck idle 0.
- Back-to-back with wren_i held high, N=8, CLK_DIV=1 -> second wr_ack_o exactly 1+2+16+2+4 cycles after the first. CS high for >=4 cycles between frames.
- wren_i pulsed during XFER -> no wr_ack_o, no err_o, frame unaffected.
- cs_sel_i=5 with N_CS=4 -> err_o pulse, no ack, idle_o stays 1, ssel stays all ones.
